// File: rtl/spk_dma.sv
// spk_dma: Avalon-MM read-master DMA for audio playback.
// Fetches number_samples 32-bit words starting at start_address with
// single-beat pipelined reads and streams them out over valid/ready.
// A small FIFO absorbs memory latency; issued-but-unreturned reads plus
// FIFO occupancy never exceed FIFO_DEPTH, so a return always has a slot.
module spk_dma #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_STEP  = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] AM_ADDR,
    output logic [2:0]  AM_BURSTCOUNT,
    output logic [3:0]  AM_BYTEENABLE,
    output logic        AM_READ,
    input  logic        AM_WAITREQUEST,
    input  logic [31:0] AM_READDATA,
    input  logic        AM_READDATAVALID,
    input  logic        start,
    input  logic [31:0] start_address,
    input  logic [31:0] number_samples,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        FINISHED
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   remaining_q, remaining_d;
    logic [31:0]   issued_q, issued_d;
    logic [31:0]   received_q, received_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          am_read_q, am_read_d;
    logic [31:0]   am_addr_q, am_addr_d;
    logic          busy_q, busy_d;
    logic          finished_q, finished_d;
    logic [31:0]   fifo_mem_q [FIFO_DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [CW-1:0] outstanding_d;
    logic [CW:0]   credit_d;

    assign accept = am_read_q && !AM_WAITREQUEST;
    // Returns are only meaningful while a transfer is active; anything
    // arriving in IDLE/FIN is a stale reply from before a reset.
    assign push   = AM_READDATAVALID && ((state_q == READ) || (state_q == DRAIN));
    assign pop    = (fifo_count_q != '0) && out_ready;

    // Next-state and next-output computation; outputs are then registered.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        issued_d     = issued_q;
        received_d   = received_q + 32'(push);
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = start_address;
                    remaining_d = number_samples;
                    issued_d    = '0;
                    received_d  = '0;
                    state_d     = (number_samples == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (accept) begin
                    addr_d   = addr_q + 32'(ADDR_STEP);
                    issued_d = issued_q + 32'd1;
                    if (issued_d == remaining_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Use next-cycle counts so FINISHED rises right after the last pop.
                if ((received_d == remaining_q) && (fifo_count_d == '0)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        outstanding_d = CW'(issued_d - received_d);
        credit_d      = {1'b0, fifo_count_d} + {1'b0, outstanding_d};
        am_read_d     = (state_d == READ) && (issued_d < remaining_d) && (credit_d < DEPTH_W);
        am_addr_d     = (state_d == READ) ? addr_d : '0;
        busy_d        = (state_d == READ) || (state_d == DRAIN);
        finished_d    = (state_d == FIN);
    end

    // FSM state, counters, FIFO pointers and registered outputs.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (RESET) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            issued_q     <= '0;
            received_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            am_read_q    <= 1'b0;
            am_addr_q    <= '0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            issued_q     <= issued_d;
            received_q   <= received_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            am_read_q    <= am_read_d;
            am_addr_q    <= am_addr_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
        end
    end

    // Sample storage written on each accepted return.
    always_ff @(posedge CLK) begin
        // NOTE: the storage array has no reset; the count and pointers define
        // which entries are live, and out_data is masked while empty.
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= AM_READDATA;
        end
    end

    // The credit rule must make an overflowing push impossible.
    always_ff @(posedge CLK) begin
        if (!RESET && push && !pop) begin
            assert (fifo_count_q < CW'(FIFO_DEPTH));
        end
    end

    assign AM_ADDR       = am_addr_q;
    assign AM_READ       = am_read_q;
    assign AM_BURSTCOUNT = 3'd1;
    assign AM_BYTEENABLE = 4'hF;
    assign busy          = busy_q;
    assign FINISHED      = finished_q;
    assign out_valid     = (fifo_count_q != '0);
    assign out_data      = out_valid ? fifo_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_spk_dma.sv
// tb_spk_dma: directed bench for spk_dma with a latency-2 memory responder,
// a waitrequest injector and an output-side monitor.
module tb_spk_dma;
    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] AM_ADDR;
    logic [2:0]  AM_BURSTCOUNT;
    logic [3:0]  AM_BYTEENABLE;
    logic        AM_READ;
    logic        AM_WAITREQUEST = 1'b0;
    logic [31:0] AM_READDATA = '0;
    logic        AM_READDATAVALID = 1'b0;
    logic        start;
    logic [31:0] start_address;
    logic [31:0] number_samples;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        FINISHED;

    spk_dma #(.FIFO_DEPTH(4), .ADDR_STEP(1)) dut (
        .CLK(CLK), .RESET(RESET),
        .AM_ADDR(AM_ADDR), .AM_BURSTCOUNT(AM_BURSTCOUNT), .AM_BYTEENABLE(AM_BYTEENABLE),
        .AM_READ(AM_READ), .AM_WAITREQUEST(AM_WAITREQUEST),
        .AM_READDATA(AM_READDATA), .AM_READDATAVALID(AM_READDATAVALID),
        .start(start), .start_address(start_address), .number_samples(number_samples),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .FINISHED(FINISHED)
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge CLK) cyc++;

    // Memory contents seen by the DMA.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Responder / monitor state.
    logic [31:0] rq_addr[$];
    int          rq_due[$];
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_rd = '0;
    int          last_pop_edge = 0;
    int          stall_at = -1;
    int          stall_left = 0;
    int          stall_seen = 0;
    bit          stall_active = 0;
    logic [31:0] stall_addr = '0;
    bit          any_read = 0;
    bit          any_valid = 0;
    bit          rv_seen = 0;
    bit          ov_seen = 0;
    int          first_rv_edge = 0;
    int          first_ov_cyc = 0;

    // Memory model and monitors, all acting mid-cycle.
    always @(negedge CLK) begin
        if (busy === 1'b1)
            check("credit_le_depth", ((acc_cnt - pop_cnt) <= 4) ? 1 : 0, 1);
        if (AM_READ === 1'b1) any_read = 1;
        if (out_valid === 1'b1) any_valid = 1;
        if (out_valid === 1'b1 && !ov_seen) begin
            ov_seen = 1;
            first_ov_cyc = cyc;
        end

        if (!RESET && out_valid === 1'b1 && out_ready) begin
            check("out_data", out_data, mem_word(exp_rd));
            exp_rd++;
            pop_cnt++;
            last_pop_edge = cyc + 1;
        end

        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            AM_READDATAVALID = 1'b1;
            AM_READDATA      = mem_word(rq_addr[0]);
            void'(rq_addr.pop_front());
            void'(rq_due.pop_front());
            if (!rv_seen) begin
                rv_seen = 1;
                first_rv_edge = cyc + 1;
            end
        end else begin
            AM_READDATAVALID = 1'b0;
            AM_READDATA      = '0;
        end

        if (stall_left > 0 && (stall_active || (acc_cnt == stall_at && AM_READ === 1'b1 && !RESET))) begin
            stall_active   = 1;
            AM_WAITREQUEST = 1'b1;
            stall_left--;
            stall_seen++;
            check("stall_am_read", AM_READ, 1);
            check("stall_am_addr", AM_ADDR, stall_addr);
        end else begin
            stall_active   = 0;
            AM_WAITREQUEST = 1'b0;
        end

        if (!RESET && AM_READ === 1'b1 && !AM_WAITREQUEST) begin
            check("addr_order", AM_ADDR, exp_addr);
            rq_addr.push_back(AM_ADDR);
            rq_due.push_back(cyc + LAT);
            exp_addr++;
            acc_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [31:0] n);
        exp_addr       = a;
        exp_rd         = a;
        acc_cnt        = 0;
        pop_cnt        = 0;
        start_address  = a;
        number_samples = n;
        start          = 1'b1;
    endtask

    task automatic wait_fin(input string tag);
        int n;
        n = 0;
        while (FINISHED !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_finished"}, FINISHED, 1);
    endtask

    task automatic drop_start(input string tag);
        start = 1'b0;
        tick();
        check({tag, "_fin_clear"}, FINISHED, 0);
        check({tag, "_busy_clear"}, busy, 0);
    endtask

    initial begin
        RESET = 1'b1; start = 1'b0; out_ready = 1'b1;
        start_address = '0; number_samples = '0;
        repeat (3) tick();
        check("rst_am_read", AM_READ, 0);
        check("rst_am_addr", AM_ADDR, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_finished", FINISHED, 0);
        check("burstcount", AM_BURSTCOUNT, 3'd1);
        check("byteenable", AM_BYTEENABLE, 4'hF);
        RESET = 1'b0;
        tick();
        check("idle_am_read", AM_READ, 0);

        // Basic transfer: 8 samples from 0x100.
        rv_seen = 0; ov_seen = 0;
        start_xfer(32'h100, 32'd8);
        tick();
        check("basic_first_read", AM_READ, 1);
        check("basic_first_addr", AM_ADDR, 32'h100);
        check("basic_busy", busy, 1);
        wait_fin("basic");
        check("basic_fin_latency", cyc, last_pop_edge);
        check("basic_issued", acc_cnt, 8);
        check("basic_popped", pop_cnt, 8);
        check("basic_valid_latency", first_ov_cyc, first_rv_edge);
        check("basic_fin_no_valid", out_valid, 0);
        drop_start("basic");

        // Waitrequest held for 5 cycles on the third request.
        stall_at = 2; stall_left = 5; stall_seen = 0; stall_addr = 32'h102;
        start_xfer(32'h100, 32'd8);
        wait_fin("stall");
        check("stall_cycles", stall_seen, 5);
        check("stall_issued", acc_cnt, 8);
        check("stall_popped", pop_cnt, 8);
        stall_at = -1;
        drop_start("stall");

        // Back-pressure: consumer stalls 20 cycles, 10 samples.
        out_ready = 1'b0;
        start_xfer(32'h200, 32'd10);
        repeat (20) tick();
        check("bp_issued_before_pop", acc_cnt, 4);
        check("bp_read_low", AM_READ, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_head", out_data, mem_word(32'h200));
        check("bp_no_pop", pop_cnt, 0);
        out_ready = 1'b1;
        wait_fin("bp");
        check("bp_fin_latency", cyc, last_pop_edge);
        check("bp_issued", acc_cnt, 10);
        check("bp_popped", pop_cnt, 10);
        drop_start("bp");

        // Zero length.
        any_read = 0; any_valid = 0;
        start_xfer(32'h300, 32'd0);
        tick();
        check("zero_finished", FINISHED, 1);
        check("zero_busy", busy, 0);
        repeat (4) tick();
        check("zero_no_read", any_read, 0);
        check("zero_no_valid", any_valid, 0);
        drop_start("zero");

        // Reset mid-transfer, then a fresh 4-sample transfer.
        begin
            int n;
            n = 0;
            start_xfer(32'h400, 32'd8);
            while (pop_cnt < 3 && n < 100) begin
                tick();
                n++;
            end
            check("midrst_reached", pop_cnt, 3);
        end
        RESET = 1'b1;
        tick();
        check("midrst_am_read", AM_READ, 0);
        check("midrst_am_addr", AM_ADDR, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_finished", FINISHED, 0);
        RESET = 1'b0; start = 1'b0;
        any_valid = 0;
        repeat (6) tick();
        check("midrst_late_ignored", any_valid, 0);
        start_xfer(32'h500, 32'd4);
        wait_fin("restart");
        check("restart_issued", acc_cnt, 4);
        check("restart_popped", pop_cnt, 4);
        drop_start("restart");

        // Held start: no retrigger until start drops.
        start_xfer(32'h600, 32'd3);
        wait_fin("held");
        any_read = 0;
        repeat (10) tick();
        check("held_still_fin", FINISHED, 1);
        check("held_no_new_read", any_read, 0);
        check("held_issued", acc_cnt, 3);
        drop_start("held");
        start_xfer(32'h700, 32'd2);
        tick();
        check("held_second_read", AM_READ, 1);
        check("held_second_addr", AM_ADDR, 32'h700);
        wait_fin("held2");
        check("held2_popped", pop_cnt, 2);
        drop_start("held2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spk_dma.md
# spk_dma

Avalon-MM read-master DMA that fetches a block of 32-bit audio samples from on-chip memory and streams them to the speaker/DAC path over a valid/ready interface. It is the playback-side counterpart of the microphone capture DMA. It shares the same control registers: start, start_address, number_samples and FINISHED. Each request is a single-beat pipelined read. A small internal FIFO decouples memory latency from the consumer's back-pressure.

## Interface
- FIFO_DEPTH, 4: sample FIFO depth; power of two, ≥2; also caps outstanding reads.
- ADDR_STEP, 1: AM_ADDR increment per sample (memory is word-addressed).
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  reset, synchronous, active-high.
- AM_ADDR  out  32  read address.
- AM_BURSTCOUNT  out  3  constant 3'd1.
- AM_BYTEENABLE  out  4  constant 4'hF.
- AM_READ  out  1  read request.
- AM_WAITREQUEST  in  1  slave stall.
- AM_READDATA  in  32  returned sample.
- AM_READDATAVALID  in  1  AM_READDATA valid this cycle.
- start  in  1  level; rising into IDLE launches a transfer; must stay high until FINISHED is seen.
- start_address  in  32  first sample address; sampled in IDLE when start=1.
- number_samples  in  32  samples to transfer, exact count; sampled with start_address.
- out_data  out  32  sample to DAC path.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- busy  out  1  high in READ and DRAIN.
- FINISHED  out  1  high in FIN only.

## Operation
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE:
  - If start=1: latch addr←start_address, remaining←number_samples, issued←0, received←0.
  - Then go to FIN if number_samples=0, else go to READ.
  - AM_READDATAVALID is ignored in IDLE; this drops stale returns after reset.
- READ:
  - AM_READ = (issued<remaining) && (fifo_count + outstanding < FIFO_DEPTH).
  - AM_ADDR = addr.
  - AM_READ and AM_READ inputs are functions of registers only; there is no combinational path from AM_WAITREQUEST or out_ready.
  - A request is accepted when AM_READ && !AM_WAITREQUEST; then addr += ADDR_STEP and issued++.
  - While AM_WAITREQUEST=1, AM_READ and AM_ADDR hold stable.
  - When the last request is accepted, go to DRAIN.
- DRAIN:
  - AM_READ=0 and AM_ADDR=0.
  - When received=remaining and the FIFO is empty, go to FIN.
- FIN:
  - FINISHED=1.
  - When start=0, go to IDLE, which clears FINISHED.
  - While start stays 1, remain in FIN; no retrigger.
- outstanding = issued − received, width clog2(FIFO_DEPTH)+1.
  - Each AM_READDATAVALID in READ/DRAIN pushes AM_READDATA into the FIFO and does received++.
  - The credit rule guarantees a push never overflows; an overflow is an assertion failure.
- FIFO:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves fifo_count unchanged, including when full or empty.
- Counters are 32-bit unsigned. Address wrap at 2^32 is modulo and is not flagged.
- Reset values: state=IDLE, AM_READ=0, AM_ADDR=0, out_valid=0, out_data=0, busy=0, FINISHED=0.
  - Counters and FIFO pointers are 0.
  - RESET mid-transfer aborts immediately, flushes the FIFO and discards in-flight reads.

## Timing
- Start is sampled in IDLE at edge k; AM_READ is high in cycle k+1 with AM_ADDR=start_address.
- With no stalls, no back-pressure and FIFO headroom, one request issues per cycle.
- AM_READDATAVALID at edge m gives out_valid=1 with that data in cycle m+1.
- If the FIFO is full and no pop occurs, AM_READ drops in the cycle after the credit is exhausted.
  - It reasserts the cycle after a pop frees a slot.
- The last pop at edge p gives FINISHED=1 in cycle p+1, provided all data has been received.
- start falling at edge q gives FINISHED=0 in cycle q+1.

## Test plan
- **Basic transfer:** start_address=0x100, number_samples=8, memory latency 2, out_ready=1.
  - Required: addresses 0x100..0x107 issued once each, in order.
  - Required: out_data matches memory contents in order.
  - Required: FINISHED rises; it clears one cycle after start drops.
- **Waitrequest stall:** AM_WAITREQUEST=1 for 5 cycles on the 3rd request.
  - Required: AM_READ and AM_ADDR=0x102 held stable throughout; no duplicate or skipped addresses.
- **Back-pressure:** out_ready=0 for 20 cycles, number_samples=10, FIFO_DEPTH=4.
  - Required: at most 4 reads issued before the first pop; outstanding+fifo_count ≤ 4 every cycle.
  - Required: all 10 samples delivered after release.
- **Zero length:** number_samples=0.
  - Required: AM_READ never asserts; FINISHED=1 in the cycle after start is sampled; out_valid stays 0.
- **Reset mid-transfer:** RESET asserted after 3 of 8 samples, with 2 reads outstanding.
  - Required: all outputs at reset values the next cycle; late AM_READDATAVALID ignored.
  - Required: a new start of 4 samples completes correctly.
- **Held start:** start kept high after FINISHED.
  - Required: stays in FIN with no new reads; start low then high launches a second transfer.
